// File: rtl/btn_event_gen_pkg.sv
//------------------------------------------------------------------------------
// Module : btn_event_gen_pkg
// Brief  : Shared stopwatch constants: button FSM encoding and ms divider helpers.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package btn_event_gen_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRESSED   = 2'd1;
    localparam logic [1:0] LONG_HELD = 2'd2;

    function automatic int ms_div(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_event_gen_tick.sv
//------------------------------------------------------------------------------
// Module : ms_tick_gen
// Brief  : Free-running 0..DIV-1 prescaler emitting a one-cycle tick at DIV-1.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ms_tick_gen #(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated so a DIV of 1 does not tick while held in clear.
    assign tick = ~clr & (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/btn_event_gen.sv
//------------------------------------------------------------------------------
// Module : btn_event_gen
// Brief  : Classifies a debounced button level into press / short-release /
//          long-press / auto-repeat single-cycle events.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_event_gen
    import btn_event_gen_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic press,
    output logic release_short,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int             DIV       = ms_div(CLK_FREQ);
    localparam int             MSW       = $clog2(max_int(LONG_MS, REPEAT_MS) + 1);
    localparam logic [MSW-1:0] LONG_LAST = MSW'(LONG_MS - 1);
    localparam logic [MSW-1:0] REP_LAST  = MSW'(REPEAT_MS - 1);

    logic [1:0]     state_q, state_d;
    logic [MSW-1:0] ms_cnt_q, ms_cnt_d;
    logic           btn_q;
    logic           press_q, press_d;
    logic           rel_q, rel_d;
    logic           long_q, long_d;
    logic           rep_q, rep_d;
    logic           held_q, held_d;
    logic           rise, fall, tick;

    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;

    // Idle holds the prescaler at zero, so the press edge restarts the ms grid.
    ms_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d  = state_q;
        ms_cnt_d = tick ? (ms_cnt_q + MSW'(1)) : ms_cnt_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end else if (tick && (ms_cnt_q == LONG_LAST)) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (tick && (ms_cnt_q == REP_LAST)) begin
                    rep_d    = 1'b1;
                    ms_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            ms_cnt_d = '0;
        end
        held_d = (state_d != IDLE);
    end

    // btn_q resets high so a button held through reset needs a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ms_cnt_q <= '0;
            btn_q    <= 1'b1;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_cnt_q <= ms_cnt_d;
            btn_q    <= btn_level;
            press_q  <= press_d;
            rel_q    <= rel_d;
            long_q   <= long_d;
            rep_q    <= rep_d;
            held_q   <= held_d;
        end
    end

    assign press         = press_q;
    assign release_short = rel_q;
    assign long_press    = long_q;
    assign repeat_pulse  = rep_q;
    assign held          = held_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_event_gen.sv
//------------------------------------------------------------------------------
// Module : tb_btn_event_gen
// Brief  : Directed self-checking bench for btn_event_gen (DIV=10, LONG=5, REP=2).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_btn_event_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_level = 1'b1;
    logic press, release_short, long_press, repeat_pulse, held;

    btn_event_gen #(
        .CLK_FREQ  (10_000),
        .LONG_MS   (5),
        .REPEAT_MS (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_level     (btn_level),
        .press         (press),
        .release_short (release_short),
        .long_press    (long_press),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log: cycle stamps of every pulse, sampled on the falling edge.
    int press_log[$];
    int rel_log[$];
    int long_log[$];
    int rep_log[$];
    int n_held    = 0;
    int n_overlap = 0;

    always @(negedge clk) begin
        if (press)         press_log.push_back(cyc);
        if (release_short) rel_log.push_back(cyc);
        if (long_press)    long_log.push_back(cyc);
        if (repeat_pulse)  rep_log.push_back(cyc);
        if (held)          n_held = n_held + 1;
        if ((int'(press) + int'(release_short) + int'(long_press) + int'(repeat_pulse)) > 1)
            n_overlap = n_overlap + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int p, p2;
    int b_press, b_rel, b_long, b_rep, b_held;

    task automatic snap();
        b_press = press_log.size();
        b_rel   = rel_log.size();
        b_long  = long_log.size();
        b_rep   = rep_log.size();
        b_held  = n_held;
    endtask

    initial begin
        // Reset with the button already held
        wait_cyc(1);
        check_eq("rst_outputs", int'({press, release_short, long_press, repeat_pulse, held}), 0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(100);
        check_eq("rst_hold_press", press_log.size(), 0);
        check_eq("rst_hold_events", rel_log.size() + long_log.size() + rep_log.size(), 0);
        check_eq("rst_hold_held", n_held, 0);
        btn_level = 1'b0;
        wait_cyc(2);
        snap();
        btn_level = 1'b1;
        p = cyc + 1;
        wait_cyc(3);
        check_eq("rst_repress_cnt", press_log.size() - b_press, 1);
        check_eq("rst_repress_at", press_log[b_press], p);
        btn_level = 1'b0;
        wait_cyc(5);

        // Short tap of 20 cycles
        snap();
        btn_level = 1'b1;
        p = cyc + 1;
        wait_cyc(20);
        btn_level = 1'b0;
        wait_cyc(10);
        check_eq("tap_press_cnt", press_log.size() - b_press, 1);
        check_eq("tap_press_at", press_log[b_press], p);
        check_eq("tap_rel_cnt", rel_log.size() - b_rel, 1);
        check_eq("tap_rel_at", rel_log[b_rel], p + 20);
        check_eq("tap_long_rep", (long_log.size() - b_long) + (rep_log.size() - b_rep), 0);
        check_eq("tap_held_cycles", n_held - b_held, 20);

        // Long hold of 100 cycles
        snap();
        btn_level = 1'b1;
        p = cyc + 1;
        wait_cyc(100);
        btn_level = 1'b0;
        wait_cyc(60);
        check_eq("long_press_at", press_log[b_press], p);
        check_eq("long_cnt", long_log.size() - b_long, 1);
        check_eq("long_at", long_log[b_long], p + 50);
        check_eq("long_rep_cnt", rep_log.size() - b_rep, 2);
        check_eq("long_rep0_at", rep_log[b_rep], p + 70);
        check_eq("long_rep1_at", rep_log[b_rep + 1], p + 90);
        check_eq("long_no_rel", rel_log.size() - b_rel, 0);
        check_eq("long_held_cycles", n_held - b_held, 100);
        check_eq("long_held_after", int'(held), 0);

        // Release on the long-threshold edge
        snap();
        btn_level = 1'b1;
        p = cyc + 1;
        wait_cyc(50);
        btn_level = 1'b0;
        wait_cyc(30);
        check_eq("thr_rel_cnt", rel_log.size() - b_rel, 1);
        check_eq("thr_rel_at", rel_log[b_rel], p + 50);
        check_eq("thr_no_long", long_log.size() - b_long, 0);
        check_eq("thr_no_rep", rep_log.size() - b_rep, 0);
        check_eq("thr_held_cycles", n_held - b_held, 50);

        // Reset in the middle of LONG_HELD
        snap();
        btn_level = 1'b1;
        p = cyc + 1;
        wait_cyc(61);
        check_eq("mid_held_pre", int'(held), 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_outputs", int'({press, release_short, long_press, repeat_pulse, held}), 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(40);
        check_eq("mid_no_rep", rep_log.size() - b_rep, 0);
        check_eq("mid_no_rel", rel_log.size() - b_rel, 0);
        check_eq("mid_press_cnt", press_log.size() - b_press, 1);
        check_eq("mid_long_cnt", long_log.size() - b_long, 1);
        btn_level = 1'b0;
        wait_cyc(2);
        btn_level = 1'b1;
        p2 = cyc + 1;
        wait_cyc(2);
        check_eq("mid_repress_cnt", press_log.size() - b_press, 2);
        check_eq("mid_repress_at", press_log[b_press + 1], p2);
        btn_level = 1'b0;
        wait_cyc(5);

        // Back-to-back single-cycle taps
        snap();
        btn_level = 1'b1;
        p = cyc + 1;
        wait_cyc(1);
        btn_level = 1'b0;
        wait_cyc(1);
        btn_level = 1'b1;
        wait_cyc(1);
        btn_level = 1'b0;
        wait_cyc(10);
        check_eq("b2b_press_cnt", press_log.size() - b_press, 2);
        check_eq("b2b_rel_cnt", rel_log.size() - b_rel, 2);
        check_eq("b2b_press0_at", press_log[b_press], p);
        check_eq("b2b_rel0_at", rel_log[b_rel], p + 1);
        check_eq("b2b_press1_at", press_log[b_press + 1], p + 2);
        check_eq("b2b_rel1_at", rel_log[b_rel + 1], p + 3);
        check_eq("b2b_no_long", long_log.size() - b_long, 0);
        check_eq("no_overlap", n_overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
